packet_checker: RTL and testbench
=================================

# packet_checker

Receive-side counterpart of the flow packet generator. Consumes AXI-Stream Ethernet frames and classifies each frame against N_FLOWS statically configured flows by destination MAC, source MAC and EtherType. For a matched frame it checks the frame length and payload fill byte against that flow's configuration. It keeps saturating per-flow good/error counters and an unmatched counter, readable through a simple registered stats port, for loopback and throughput tests.

## Interface
Parameters:
- DATA_WIDTH, 512 — stream width in bits; legal values 128, 256, 512.
- N_FLOWS, 4 — number of flows; range 1–64.
- SIZES, {11'd192 ×4} — expected MAC frame length in bytes. Flow i is at [11*(i+1)-1:11*i].
- D_MACS, {48'hABCDEF000001 … 48'hABCDEF000004} — destination MAC per flow; 48-bit slices, packed the same way.
- S_MACS, {48'hBEEFBEEF0001 … 48'hBEEFBEEF0004} — source MAC per flow.
- ETHERTYPES, {16'h0800 ×4} — EtherType per flow.
- PAYLOADS, {8'hAA, 8'hBB, 8'hCC, 8'hDD} — fill byte expected at every byte after byte 13.

Ports:
- clk  in  1  — sole clock.
- rst  in  1  — synchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  — frame data; byte k is at [8k+7:8k] and is the k-th byte on the wire.
- s_axis_tkeep  in  DATA_WIDTH/8  — byte enables; contiguous from bit 0.
- s_axis_tvalid  in  1  — beat valid.
- s_axis_tlast  in  1  — last beat of frame.
- s_axis_tready  out  1  — 0 in reset, 1 otherwise.
- stat_addr  in  8  — counter select: 2i = good count of flow i; 2i+1 = error count of flow i; 2*N_FLOWS = unmatched count; any other value reads 0.
- stat_data  out  32  — selected counter, registered.
- stat_clear  in  1  — one-cycle pulse that zeroes all counters.
- pkt_done  out  1  — one-cycle pulse per completed frame.
- pkt_ok  out  1  — verdict for the completed frame; valid with pkt_done.
- pkt_matched  out  1  — frame matched a flow; valid with pkt_done.
- pkt_flow  out  6  — matched flow index; valid with pkt_done when pkt_matched=1.

## Operation
- A beat is accepted when s_axis_tvalid=1 and s_axis_tready=1.
- FSM states:
  - IDLE: next accepted beat is a frame's first beat.
  - BODY: mid-frame.
  - IDLE→BODY on an accepted first beat with tlast=0.
  - BODY→IDLE on an accepted beat with tlast=1.
  - An accepted first beat with tlast=1 stays in IDLE.
- Header extraction (first beat):
  - d_mac = bytes 0..5; byte 0 maps to d_mac[47:40].
  - s_mac = bytes 6..11, same byte order.
  - ethertype = {byte12, byte13}.
- Flow match: the first flow index i, counting up from 0, whose D_MAC, S_MAC and ETHERTYPE all equal the header wins. No such flow means unmatched.
- Match result is registered at the first beat and held for the rest of the frame.
- Runt: a first beat with fewer than 14 tkeep bits set is forced unmatched.
- Length: running sum of the popcount of tkeep over all beats.
  - Counter is 16 bits and saturates at 0xFFFF.
  - The frame passes the length check only if the final sum equals SIZES[flow].
- Payload check: every kept byte with wire index ≥14 must equal PAYLOADS[flow]. Any mismatch sets a sticky per-frame error flag.
  - For unmatched frames the payload and length checks are skipped.
- Frame completion (tlast beat accepted):
  - Matched, no error, length equal → good[flow] += 1, pkt_ok=1.
  - Matched, otherwise → err[flow] += 1, pkt_ok=0.
  - Unmatched → unmatched += 1, pkt_ok=0, pkt_matched=0.
- All counters are 32 bits and saturate at 0xFFFFFFFF.
- stat_clear coinciding with a counter update: clear wins and the update is lost.
- Reset values:
  - s_axis_tready=0, stat_data=0, pkt_done=0, pkt_ok=0, pkt_matched=0, pkt_flow=0.
  - All counters 0; FSM in IDLE.
- Reset mid-frame: the partial frame is discarded with no counter update. The first beat accepted after reset is treated as a new frame header.

## Timing
- s_axis_tready rises the cycle after rst deasserts and never drops outside reset. The block sustains one beat per cycle with no bubbles.
- Verdict latency:
  - pkt_done, pkt_ok, pkt_matched and pkt_flow assert the cycle after the tlast beat is accepted.
  - The counter increment is visible in that same cycle.
- Back-to-back frames: a first beat in the cycle after tlast is handled normally. pkt_done can pulse every cycle for single-beat frames.
- stat_data latency: stat_data reflects stat_addr and counter state sampled at the previous edge (1-cycle latency).
- stat_clear takes effect at the next edge; counters read 0 one cycle later via stat_data.
- tvalid=0 gaps mid-frame are permitted and state is held across them.

## Test plan
- Flow 0 frame: dst ABCDEF000004, src BEEFBEEF0004, type 0800, 178 bytes of 0xDD, 192 bytes total in 3 full 64-byte beats → pkt_done with ok=1, flow=0; stat_addr=0 reads 1.
- Same header with byte 100 = 0x00 → pkt_ok=0; stat_addr=1 reads 1; stat_addr=0 unchanged.
- Flow 3 frame (ABCDEF000001 / BEEFBEEF0001, fill 0xAA) with the last beat's tkeep = 0x7FFFFFFFFFFFFFFF (191 bytes) → err[3]=1 (stat_addr=7 reads 1).
- Dst FFFFFFFFFFFF frame, then a 10-byte single-beat runt → stat_addr=8 reads 2, with pkt_matched=0 both times.
- 4 back-to-back good flow 1 frames with random tvalid gaps, then rst asserted mid-frame, then stat read → all counters 0; frames after reset counted correctly.
- stat_clear asserted in the same cycle as a good-frame completion → all counters read 0; counter at 0xFFFFFFFF holds on a further event.

Source files
------------

// File: rtl/packet_checker.sv
// rtl/packet_checker.sv - receive-side frame classifier and per-flow checker with saturating stats
// Purpose: classifies each AXI-Stream Ethernet frame against N_FLOWS static flows
//          (dst MAC, src MAC, EtherType), checks length and payload fill of matched
//          frames, and keeps saturating good/error/unmatched counters.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   s_axis_tdata/tkeep/tvalid/tlast, s_axis_tready - frame input stream
//   stat_addr, stat_data          - counter select and registered read data
//   stat_clear                    - pulse that zeroes all counters
//   pkt_done, pkt_ok, pkt_matched, pkt_flow - per-frame verdict, one cycle after tlast
module packet_checker #(
    parameter int                    DATA_WIDTH = 512,
    parameter int                    N_FLOWS    = 4,
    parameter logic [11*N_FLOWS-1:0] SIZES      = {4{11'd192}},
    parameter logic [48*N_FLOWS-1:0] D_MACS     = {48'hABCDEF000001, 48'hABCDEF000002,
                                                   48'hABCDEF000003, 48'hABCDEF000004},
    parameter logic [48*N_FLOWS-1:0] S_MACS     = {48'hBEEFBEEF0001, 48'hBEEFBEEF0002,
                                                   48'hBEEFBEEF0003, 48'hBEEFBEEF0004},
    parameter logic [16*N_FLOWS-1:0] ETHERTYPES = {4{16'h0800}},
    parameter logic [8*N_FLOWS-1:0]  PAYLOADS   = {8'hAA, 8'hBB, 8'hCC, 8'hDD}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    input  logic [7:0]              stat_addr,
    output logic [31:0]             stat_data,
    input  logic                    stat_clear,
    output logic                    pkt_done,
    output logic                    pkt_ok,
    output logic                    pkt_matched,
    output logic [5:0]              pkt_flow
);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic {IDLE, BODY} state_t;

    state_t      state_q, state_d;
    logic        ready_q;
    logic [15:0] len_q;
    logic        match_q;
    logic [5:0]  flow_q;
    logic        perr_q;
    logic        done_q, ok_q, matched_q;
    logic [5:0]  pkt_flow_q;
    logic [31:0] stat_q;
    logic [31:0] good_q [N_FLOWS];
    logic [31:0] err_q  [N_FLOWS];
    logic [31:0] unm_q;

    logic        beat, first;
    logic [15:0] keep_cnt;
    logic [47:0] d_mac, s_mac;
    logic [15:0] etype;
    logic        hit;
    logic [5:0]  hit_flow;
    logic        cur_match;
    logic [5:0]  cur_flow;
    logic [7:0]  fill;
    logic [10:0] exp_size;
    logic [15:0] len_base, len_new;
    logic [16:0] len_sum;
    logic        beat_err, frame_err, frame_ok, done_d;
    logic [31:0] stat_mux;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        beat  = s_axis_tvalid && ready_q;
        first = (state_q == IDLE);

        keep_cnt = '0;
        for (int k = 0; k < NB; k++) keep_cnt = keep_cnt + {15'd0, s_axis_tkeep[k]};

        // Byte 0 on the wire is the MSB of the MAC address.
        d_mac = '0;
        s_mac = '0;
        for (int j = 0; j < 6; j++) begin
            d_mac[8*(5-j) +: 8] = s_axis_tdata[8*j +: 8];
            s_mac[8*(5-j) +: 8] = s_axis_tdata[8*(6+j) +: 8];
        end
        etype = {s_axis_tdata[103:96], s_axis_tdata[111:104]};

        // Scan downwards so the lowest matching index is the one left standing.
        hit      = 1'b0;
        hit_flow = '0;
        for (int i = N_FLOWS - 1; i >= 0; i--) begin
            if (d_mac == D_MACS[48*i +: 48] && s_mac == S_MACS[48*i +: 48] &&
                etype == ETHERTYPES[16*i +: 16]) begin
                hit      = 1'b1;
                hit_flow = 6'(i);
            end
        end

        // A first beat too short to hold a full header can never match.
        cur_match = first ? (hit && keep_cnt >= 16'd14) : match_q;
        cur_flow  = first ? hit_flow : flow_q;

        fill     = '0;
        exp_size = '0;
        for (int i = 0; i < N_FLOWS; i++) begin
            if (cur_flow == 6'(i)) begin
                fill     = PAYLOADS[8*i +: 8];
                exp_size = SIZES[11*i +: 11];
            end
        end

        len_base = first ? 16'd0 : len_q;
        len_sum  = {1'b0, len_base} + {1'b0, keep_cnt};
        len_new  = len_sum[16] ? 16'hFFFF : len_sum[15:0];

        // The running length is also the wire offset of this beat's byte 0.
        beat_err = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (s_axis_tkeep[k] && ({1'b0, len_base} + 17'(k) >= 17'd14) &&
                s_axis_tdata[8*k +: 8] != fill)
                beat_err = 1'b1;
        end
        frame_err = (first ? 1'b0 : perr_q) | beat_err;
        frame_ok  = cur_match && !frame_err && (len_new == {5'd0, exp_size});
        done_d    = beat && s_axis_tlast;

        state_d = state_q;
        if (beat) state_d = s_axis_tlast ? IDLE : BODY;

        stat_mux = '0;
        for (int i = 0; i < N_FLOWS; i++) begin
            if (stat_addr == 8'(2*i))     stat_mux = good_q[i];
            if (stat_addr == 8'(2*i + 1)) stat_mux = err_q[i];
        end
        if (stat_addr == 8'(2*N_FLOWS)) stat_mux = unm_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            len_q      <= '0;
            match_q    <= 1'b0;
            flow_q     <= '0;
            perr_q     <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            matched_q  <= 1'b0;
            pkt_flow_q <= '0;
            stat_q     <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= 1'b1;
            stat_q     <= stat_mux;
            done_q     <= done_d;
            ok_q       <= done_d && frame_ok;
            matched_q  <= done_d && cur_match;
            pkt_flow_q <= (done_d && cur_match) ? cur_flow : 6'd0;
            if (beat) begin
                len_q   <= len_new;
                match_q <= cur_match;
                flow_q  <= cur_flow;
                perr_q  <= frame_err;
            end
        end
    end

    // Clear has priority over an update landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            for (int i = 0; i < N_FLOWS; i++) begin
                good_q[i] <= '0;
                err_q[i]  <= '0;
            end
            unm_q <= '0;
        end else if (done_d) begin
            if (!cur_match) begin
                unm_q <= sat_inc(unm_q);
            end else begin
                for (int i = 0; i < N_FLOWS; i++) begin
                    if (cur_flow == 6'(i)) begin
                        if (frame_ok) good_q[i] <= sat_inc(good_q[i]);
                        else          err_q[i]  <= sat_inc(err_q[i]);
                    end
                end
            end
        end
    end

    assign s_axis_tready = ready_q;
    assign stat_data     = stat_q;
    assign pkt_done      = done_q;
    assign pkt_ok        = ok_q;
    assign pkt_matched   = matched_q;
    assign pkt_flow      = pkt_flow_q;
endmodule

// File: tb/tb_packet_checker.sv
// tb/tb_packet_checker.sv - scoreboard bench for packet_checker with randomized frames
module tb_packet_checker;
    localparam int NB = 64;
    localparam int NF = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [511:0]   tdata;
    logic [63:0]    tkeep;
    logic           tvalid, tlast, tready;
    logic [7:0]     stat_addr;
    logic [31:0]    stat_data;
    logic           stat_clear;
    logic           pkt_done, pkt_ok, pkt_matched;
    logic [5:0]     pkt_flow;

    packet_checker #(.DATA_WIDTH(512), .N_FLOWS(4)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tready(tready),
        .stat_addr(stat_addr), .stat_data(stat_data), .stat_clear(stat_clear),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pkt_matched(pkt_matched), .pkt_flow(pkt_flow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ok;
        logic       matched;
        logic [5:0] flow;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  frm[$];
    logic [31:0] exp_good[NF];
    logic [31:0] exp_err[NF];
    logic [31:0] exp_unm;
    int          tests = 0;
    int          fails = 0;

    // Flow table: flow 0 is the lowest packed slice of the default parameters.
    function automatic logic [47:0] dm(input int f);
        return 48'hABCDEF000004 - 48'(f);
    endfunction
    function automatic logic [47:0] sm(input int f);
        return 48'hBEEFBEEF0004 - 48'(f);
    endfunction
    function automatic logic [7:0] fl(input int f);
        return 8'hDD - 8'(f * 17);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic build_frame(input logic [47:0] d, input logic [47:0] s,
                               input logic [15:0] t, input logic [7:0] f, input int len);
        frm.delete();
        for (int j = 0; j < len; j++) begin
            if (j < 6)        frm.push_back(d[8*(5-j) +: 8]);
            else if (j < 12)  frm.push_back(s[8*(11-j) +: 8]);
            else if (j == 12) frm.push_back(t[15:8]);
            else if (j == 13) frm.push_back(t[7:0]);
            else              frm.push_back(f);
        end
    endtask

    function automatic exp_t model_frame();
        exp_t        e;
        int          n;
        logic [47:0] d, s;
        logic [15:0] t;
        e = '0;
        n = frm.size();
        if (n >= 14) begin
            d = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
            s = {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]};
            t = {frm[12], frm[13]};
            for (int f = 0; f < NF; f++) begin
                if (!e.matched && d == dm(f) && s == sm(f) && t == 16'h0800) begin
                    e.matched = 1'b1;
                    e.flow    = 6'(f);
                end
            end
        end
        if (e.matched) begin
            e.ok = (n == 192);
            for (int j = 14; j < n; j++)
                if (frm[j] != fl(int'(e.flow))) e.ok = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] exp_stat(input logic [7:0] a);
        int idx;
        idx = int'(a) / 2;
        if (int'(a) < 2 * NF) return a[0] ? exp_err[idx] : exp_good[idx];
        if (int'(a) == 2 * NF) return exp_unm;
        return 32'd0;
    endfunction

    task automatic zero_model();
        for (int i = 0; i < NF; i++) begin
            exp_good[i] = 0;
            exp_err[i]  = 0;
        end
        exp_unm = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tvalid = 1'b0; tlast = 1'b0; stat_clear = 1'b0;
            tdata = '0; tkeep = '0;
        end
    endtask

    // Drives frm; trunc sends only two beats and no tlast (abandoned frame).
    task automatic drive(input bit gaps, input bit clr_last, input bit trunc);
        int n, off;
        n = frm.size();
        off = 0;
        while (off < n && (!trunc || off < 2 * NB)) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    tvalid = 1'b0; tlast = 1'b0;
                end
            end
            @(negedge clk);
            tdata = '0; tkeep = '0;
            for (int k = 0; k < NB && off + k < n; k++) begin
                tdata[8*k +: 8] = frm[off + k];
                tkeep[k] = 1'b1;
            end
            off += NB;
            tvalid = 1'b1;
            tlast = (off >= n) && !trunc;
            stat_clear = clr_last && tlast;
        end
    endtask

    task automatic issue(input bit gaps, input bit clr_last);
        exp_t e;
        e = model_frame();
        sbq.push_back(e);
        if (clr_last) begin
            zero_model();
        end else if (!e.matched) begin
            if (exp_unm != 32'hFFFF_FFFF) exp_unm++;
        end else if (e.ok) begin
            if (exp_good[e.flow] != 32'hFFFF_FFFF) exp_good[e.flow]++;
        end else begin
            if (exp_err[e.flow] != 32'hFFFF_FFFF) exp_err[e.flow]++;
        end
        drive(gaps, clr_last, 1'b0);
    endtask

    task automatic check_stat(input logic [7:0] a);
        logic [31:0] want;
        @(negedge clk);
        stat_addr = a;
        want = exp_stat(a);
        @(negedge clk);
        check($sformatf("stat[%0d]", a), stat_data, want);
    endtask

    task automatic check_all_stats();
        for (int a = 0; a <= 2 * NF + 1; a++) check_stat(8'(a));
        check_stat(8'd200);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && pkt_done) begin
            if (sbq.size() == 0) begin
                check("unexpected_pkt_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                tests++;
                if (pkt_ok !== e.ok || pkt_matched !== e.matched ||
                    (e.matched && pkt_flow !== e.flow)) begin
                    fails++;
                    $display("FAIL verdict: got ok=%0b matched=%0b flow=%0d expected ok=%0b matched=%0b flow=%0d",
                             pkt_ok, pkt_matched, pkt_flow, e.ok, e.matched, e.flow);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int f, kind, len;
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tkeep = '0;
        stat_addr = 8'd0; stat_clear = 1'b0;
        zero_model();
        repeat (3) @(negedge clk);
        check("reset_tready", {31'd0, tready}, 32'd0);
        check("reset_stat_data", stat_data, 32'd0);
        check("reset_pkt", {26'd0, pkt_done, pkt_ok, pkt_matched, pkt_flow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_reset", {31'd0, tready}, 32'd1);

        // Directed frames.
        build_frame(dm(0), sm(0), 16'h0800, fl(0), 192);
        issue(1'b0, 1'b0); idle(2);
        check_stat(8'd0);
        build_frame(dm(0), sm(0), 16'h0800, fl(0), 192);
        frm[100] = 8'h00;
        issue(1'b0, 1'b0); idle(2);
        check_stat(8'd1); check_stat(8'd0);
        build_frame(dm(3), sm(3), 16'h0800, fl(3), 192);
        void'(frm.pop_back());
        issue(1'b0, 1'b0); idle(2);
        check_stat(8'd7);
        build_frame(48'hFFFFFFFFFFFF, sm(0), 16'h0800, fl(0), 192);
        issue(1'b0, 1'b0);
        build_frame(dm(0), sm(0), 16'h0800, fl(0), 10);
        issue(1'b0, 1'b0); idle(2);
        check_stat(8'd8);

        // Randomized frames, back-to-back unless gaps are drawn.
        for (int i = 0; i < 40; i++) begin
            f = $urandom_range(0, NF - 1);
            kind = $urandom_range(0, 5);
            len = 192;
            if (kind == 0) len = $urandom_range(1, 64);
            if (kind == 1) len = $urandom_range(14, 260);
            build_frame((kind == 3) ? {$urandom, 16'h1234} : dm(f),
                        (kind == 4) ? sm((f + 1) % NF) : sm(f),
                        (kind == 5 && i[0]) ? 16'h86DD : 16'h0800, fl(f), len);
            if (kind == 2) frm[$urandom_range(14, 191)] ^= 8'(1 << $urandom_range(0, 7));
            issue(1'($urandom_range(0, 1)), 1'b0);
        end
        idle(2);
        check_all_stats();

        // Back-to-back flow 1 frames with gaps, then reset mid-frame.
        repeat (4) begin
            build_frame(dm(1), sm(1), 16'h0800, fl(1), 192);
            issue(1'b1, 1'b0);
        end
        build_frame(dm(1), sm(1), 16'h0800, fl(1), 192);
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        tvalid = 1'b0; rst = 1'b1;
        zero_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);
        check_all_stats();
        build_frame(dm(1), sm(1), 16'h0800, fl(1), 192);
        issue(1'b0, 1'b0);
        build_frame(dm(2), sm(2), 16'h0800, fl(2), 130);
        issue(1'b0, 1'b0); idle(2);
        check_stat(8'd2); check_stat(8'd5);

        // Clear coinciding with a good-frame completion.
        build_frame(dm(0), sm(0), 16'h0800, fl(0), 192);
        issue(1'b0, 1'b0);
        build_frame(dm(2), sm(2), 16'h0800, fl(2), 192);
        issue(1'b0, 1'b1); idle(2);
        check_all_stats();
        build_frame(dm(2), sm(2), 16'h0800, fl(2), 192);
        issue(1'b1, 1'b0); idle(2);
        check_stat(8'd4);

        idle(3);
        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
